// File: rtl/tri_bus_pkg.sv
// Shared types and constants for the tri_bus_drv tristate bus driver.
package tri_bus_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRIVE = 2'd2,
    TURN  = 2'd3
  } state_e;

endpackage

// File: rtl/tri_bus_drv.sv
// Tristate bus driver: request, drive for HOLD_CYCLES, release for TURN_CYCLES.
// Optional receive capture path is compiled in when TRI_BUS_DRV_RX_EN is defined.
module tri_bus_drv
  import tri_bus_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             bus_req,
  input  logic             bus_gnt,
  inout  wire  [WIDTH-1:0] bus,
  output logic             bus_oe,
  output logic             tx_done,
  output logic             tx_abort,
  input  logic             bus_sample,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             ready_q, ready_d;
  logic             req_q, req_d;
  logic             drive_q, drive_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid && ready_q) begin
          hold_d  = tx_data;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus_gnt) begin
          state_d = DRIVE;
          cnt_d   = HOLD_LOAD;
        end else begin
          state_d = REQ;
        end
      end
      DRIVE: begin
        // Losing grant wins over a normal completion on the last cycle
        if (!bus_gnt) begin
          abort_d = 1'b1;
          state_d = TURN;
          cnt_d   = TURN_LOAD;
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          done_d  = 1'b1;
          state_d = TURN;
          cnt_d   = TURN_LOAD;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      TURN: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
    ready_d = (state_d == IDLE);
    req_d   = (state_d == REQ) || (state_d == DRIVE);
    drive_d = (state_d == DRIVE);
  end

  // State, counter, held word and status flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      hold_q  <= {WIDTH{1'b0}};
      ready_q <= 1'b0;
      req_q   <= 1'b0;
      drive_q <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      ready_q <= ready_d;
      req_q   <= req_d;
      drive_q <= drive_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  // Grant is gated in combinationally so a lost grant frees the bus in the same cycle
  assign bus_oe   = drive_q & bus_gnt;
  assign bus      = bus_oe ? hold_q : {WIDTH{1'bz}};
  assign tx_ready = ready_q;
  assign bus_req  = req_q;
  assign tx_done  = done_q;
  assign tx_abort = abort_q;

`ifdef TRI_BUS_DRV_RX_EN
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;

  // Capture another agent's word only while this block is not driving
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    if (bus_sample && !bus_oe) begin
      rx_data_d  = bus;
      rx_valid_d = 1'b1;
    end else begin
      rx_valid_d = 1'b0;
    end
  end

  // Receive register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data_q  <= {WIDTH{1'b0}};
      rx_valid_q <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`else
  logic rx_unused_s;

  assign rx_unused_s = ^{bus_sample, bus};
  assign rx_data     = {WIDTH{1'b0}};
  assign rx_valid    = 1'b0;
`endif

endmodule

// File: doc/tri_bus_drv.md
TRI_BUS_DRV -- requirements
Module: tri_bus_drv

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bus and data width in bits.
REQ-002 SHALL have parameter HOLD_CYCLES, default 2, cycles the bus is driven per transfer, legal range 1..15.
REQ-003 SHALL have parameter TURN_CYCLES, default 1, bus-release cycles after driving, legal range 1..15.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port tx_data, input, WIDTH, word to place on the bus.
REQ-007 SHALL have port tx_valid, input, 1, tx_data valid.
REQ-008 SHALL have port tx_ready, output, 1, block accepts a word this cycle.
REQ-009 SHALL have port bus_req, output, 1, request for bus ownership.
REQ-010 SHALL have port bus_gnt, input, 1, bus ownership granted.
REQ-011 SHALL have port bus, inout, WIDTH, shared tristate data bus.
REQ-012 SHALL have port bus_oe, output, 1, high while this block drives bus.
REQ-013 SHALL have port tx_done, output, 1, one-cycle pulse when a transfer completes normally.
REQ-014 SHALL have port tx_abort, output, 1, one-cycle pulse when grant is lost while driving.
REQ-015 SHALL have port bus_sample, input, 1, another agent's strobe marking bus contents valid.
REQ-016 SHALL have port rx_data, output, WIDTH, last word captured from the bus.
REQ-017 SHALL have port rx_valid, output, 1, one-cycle pulse when rx_data updates.

Function
REQ-018 SHALL implement states IDLE, REQ, DRIVE, TURN.
REQ-019 SHALL assert tx_ready only in IDLE; a handshake occurs on tx_valid && tx_ready.
REQ-020 SHALL, on handshake, latch tx_data into a holding register and enter REQ next cycle.
REQ-021 SHALL assert bus_req in REQ and DRIVE, and deassert it in IDLE and TURN.
REQ-022 SHALL, in REQ with bus_gnt high, enter DRIVE next cycle; otherwise remain in REQ indefinitely.
REQ-023 SHALL drive bus with the held word, and set bus_oe high, for exactly HOLD_CYCLES cycles in DRIVE; in all other states bus SHALL be high-impedance and bus_oe low.
REQ-024 SHALL, on the last DRIVE cycle with bus_gnt still high, pulse tx_done for one cycle and enter TURN.
REQ-025 SHALL, if bus_gnt is low in any DRIVE cycle, release bus in that same cycle (combinational on gnt), pulse tx_abort for one cycle, suppress tx_done, and enter TURN.
REQ-026 SHALL remain in TURN for exactly TURN_CYCLES cycles, then enter IDLE.
REQ-027 SHALL use a 4-bit down-counter shared by DRIVE and TURN, loaded on state entry.
REQ-028 SHALL, when bus_oe is low and bus_sample is high, capture bus into rx_data and pulse rx_valid on the next cycle; bus_sample while bus_oe is high SHALL be ignored.
REQ-029 SHALL sustain back-to-back transfers: minimum period is 1 + 1 + HOLD_CYCLES + TURN_CYCLES cycles per accepted word.

Reset
REQ-030 SHALL, while reset_n is low, force state IDLE, bus_oe 0, bus high-impedance, bus_req 0, tx_ready 0, tx_done 0, tx_abort 0, rx_valid 0, rx_data 0, and counter 0.
REQ-031 SHALL, on reset assertion mid-transfer, release the bus immediately and discard the held word; no tx_done or tx_abort SHALL be produced.
REQ-032 SHALL assert tx_ready on the first clock edge after reset_n deasserts.

Configuration
REQ-033 SHALL compile the receive capture path only when TRI_BUS_DRV_RX_EN is defined; when it is undefined, rx_data SHALL be tied to 0, rx_valid to 0, bus_sample SHALL be unused, and transmit behaviour SHALL be unchanged.

Structure
REQ-034 SHALL place the state enum type (IDLE, REQ, DRIVE, TURN) and the counter-width constant in shared package tri_bus_pkg.
REQ-035 SHALL be a single module without sub-modules; the tristate buffer SHALL be a continuous conditional assignment on bus.

Verification
REQ-036 Basic: handshake tx_data=8'hA5 with bus_gnt high -> bus=8'hA5 with bus_oe=1 for 2 cycles, tx_done pulses, bus=Z for 1 cycle, then tx_ready=1.
REQ-037 Grant delay: bus_gnt held low 5 cycles after handshake -> bus_req high throughout, bus_oe stays 0 until the cycle after gnt rises.
REQ-038 Abort: drop bus_gnt in the first DRIVE cycle -> bus=Z and bus_oe=0 in the same cycle, tx_abort pulses once, no tx_done.
REQ-039 Receive (RX_EN defined): external agent drives 8'h3C with bus_sample=1 while idle -> rx_data=8'h3C and rx_valid pulses next cycle; sample during own DRIVE -> no rx_valid.
REQ-040 Reset mid-DRIVE: pulse reset_n low -> bus=Z immediately, all outputs 0, tx_ready=1 one edge after release.
REQ-041 Back-to-back: tx_valid held high with words 01,02,03 -> three transfers, each 5 cycles apart, in order.
